model_matrix_vector_product_stream: RTL and testbench

//   Streaming signed fixed-width matrix-vector product engine, the parametrised successor of the NTM algebra matrix blocks.

---
 rtl/model_matrix_vector_product_stream.sv | 184 ++++++++++++++++++
 tb/tb_model_matrix_vector_product_stream.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/model_matrix_vector_product_stream.sv
// Streaming signed matrix-vector product: buffers b, streams A row-major with one MAC
// per accepted element, then emits y = A*b (MODE=0) or y = A^T*b (MODE=1), saturated.

module model_mvp_acc_lane #(
    parameter int AW = 132
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [AW-1:0] i_add,
    output logic [AW-1:0] o_acc
);
    logic [AW-1:0] r_acc;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)       r_acc <= '0;
        else if (i_clr) r_acc <= '0;
        else if (i_en)  r_acc <= r_acc + i_add;
    end

    assign o_acc = r_acc;
endmodule

module model_matrix_vector_product_stream #(
    parameter int DATA_SIZE = 64,
    parameter int MAX_SIZE  = 16,
    parameter int ADDR_SIZE = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 MODE,
    input  logic [DATA_SIZE-1:0] SIZE_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_J_IN,
    input  logic                 DATA_B_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] DATA_B_IN,
    input  logic                 DATA_A_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] DATA_A_IN,
    output logic                 DATA_OUT_ENABLE,
    output logic                 DATA_OUT_LAST,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 READY,
    output logic                 ERROR
);
    localparam int AW = 2*DATA_SIZE + ADDR_SIZE;
    localparam int CW = ADDR_SIZE + 1;
    localparam int PW = 2*DATA_SIZE;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_B, S_LOAD_A, S_OUTPUT, S_DONE} state_t;

    state_t                r_state, w_next;
    logic                  r_mode, r_err;
    logic [CW-1:0]         r_si, r_sj, r_k;
    logic [ADDR_SIZE-1:0]  r_i, r_j;
    logic [DATA_SIZE-1:0]  r_b [MAX_SIZE];
    logic                  r_out_en, r_out_last, r_ready, r_error;
    logic [DATA_SIZE-1:0]  r_out;

    logic                  w_start, w_size_bad, w_b_fire, w_a_fire;
    logic                  w_b_last, w_i_last, w_j_last, w_a_last, w_y_last;
    logic [CW-1:0]         w_nb, w_ny;
    logic [ADDR_SIZE-1:0]  w_lane;
    logic [DATA_SIZE-1:0]  w_bsel;
    logic signed [PW-1:0]  w_a_ext, w_b_ext, w_prod;
    logic [AW-1:0]         w_add;
    logic [MAX_SIZE-1:0][AW-1:0] w_acc;
    logic [AW-1:0]         w_sel_acc;
    logic [AW-DATA_SIZE:0] w_hi;
    logic [DATA_SIZE-1:0]  w_sat;

    // Sizes are treated as unsigned, so a negative size reads as oversized.
    assign w_start    = (r_state == S_IDLE) && START;
    assign w_size_bad = (SIZE_I_IN == '0) || (SIZE_I_IN > DATA_SIZE'(MAX_SIZE)) ||
                        (SIZE_J_IN == '0) || (SIZE_J_IN > DATA_SIZE'(MAX_SIZE));
    assign w_nb       = r_mode ? r_si : r_sj;
    assign w_ny       = r_mode ? r_sj : r_si;
    assign w_b_fire   = (r_state == S_LOAD_B) && DATA_B_IN_ENABLE;
    assign w_a_fire   = (r_state == S_LOAD_A) && DATA_A_IN_ENABLE;
    assign w_b_last   = (r_k == w_nb - CW'(1));
    assign w_i_last   = ({1'b0, r_i} == r_si - CW'(1));
    assign w_j_last   = ({1'b0, r_j} == r_sj - CW'(1));
    assign w_a_last   = w_i_last && w_j_last;
    assign w_y_last   = (r_k == w_ny - CW'(1));

    // Transpose only swaps which index picks b and which picks the accumulator.
    assign w_lane  = r_mode ? r_j : r_i;
    assign w_bsel  = r_mode ? r_b[r_i] : r_b[r_j];
    assign w_a_ext = {{DATA_SIZE{DATA_A_IN[DATA_SIZE-1]}}, DATA_A_IN};
    assign w_b_ext = {{DATA_SIZE{w_bsel[DATA_SIZE-1]}}, w_bsel};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_add   = {{ADDR_SIZE{w_prod[PW-1]}}, w_prod};

    genvar g;
    generate
        for (g = 0; g < MAX_SIZE; g++) begin : g_lane
            model_mvp_acc_lane #(.AW(AW)) u_lane (
                .CLK   (CLK),
                .RST   (RST),
                .i_clr (w_start),
                .i_en  (w_a_fire && (w_lane == ADDR_SIZE'(g))),
                .i_add (w_add),
                .o_acc (w_acc[g])
            );
        end
    endgenerate

    assign w_sel_acc = w_acc[r_k[ADDR_SIZE-1:0]];
    assign w_hi      = w_sel_acc[AW-1:DATA_SIZE-1];
    assign w_sat     = ((&w_hi) || !(|w_hi)) ? w_sel_acc[DATA_SIZE-1:0] :
                       w_sel_acc[AW-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                       : {1'b0, {(DATA_SIZE-1){1'b1}}};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (START) w_next = w_size_bad ? S_DONE : S_LOAD_B;
            S_LOAD_B: if (w_b_fire && w_b_last) w_next = S_LOAD_A;
            S_LOAD_A: if (w_a_fire && w_a_last) w_next = S_OUTPUT;
            S_OUTPUT: if (w_y_last) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_mode <= 1'b0;
            r_err  <= 1'b0;
            r_si   <= '0;
            r_sj   <= '0;
            r_k    <= '0;
            r_i    <= '0;
            r_j    <= '0;
            for (int n = 0; n < MAX_SIZE; n++) r_b[n] <= '0;
        end else begin
            if (w_start) begin
                r_mode <= MODE;
                r_err  <= w_size_bad;
                r_si   <= SIZE_I_IN[CW-1:0];
                r_sj   <= SIZE_J_IN[CW-1:0];
                r_k    <= '0;
                r_i    <= '0;
                r_j    <= '0;
            end
            if (w_b_fire) begin
                r_b[r_k[ADDR_SIZE-1:0]] <= DATA_B_IN;
                r_k <= w_b_last ? '0 : r_k + CW'(1);
            end
            if (w_a_fire) begin
                r_j <= w_j_last ? '0 : r_j + ADDR_SIZE'(1);
                if (w_j_last) r_i <= r_i + ADDR_SIZE'(1);
            end
            if (r_state == S_OUTPUT) r_k <= r_k + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_out_en   <= 1'b0;
            r_out_last <= 1'b0;
            r_out      <= '0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_out_en   <= (r_state == S_OUTPUT);
            r_out_last <= (r_state == S_OUTPUT) && w_y_last;
            r_ready    <= (r_state == S_DONE);
            r_error    <= (r_state == S_DONE) && r_err;
            if (r_state == S_OUTPUT) r_out <= w_sat;
        end
    end

    assign DATA_OUT_ENABLE = r_out_en;
    assign DATA_OUT_LAST   = r_out_last;
    assign DATA_OUT        = r_out;
    assign READY           = r_ready;
    assign ERROR           = r_error;
endmodule

// File: tb/tb_model_matrix_vector_product_stream.sv
// Scoreboard bench: the driver pushes expected outputs and READY/ERROR flags, a negedge
// monitor pops and compares whatever the DUT presents.

module tb_model_matrix_vector_product_stream;
    localparam int DS = 64;
    localparam int MS = 16;

    typedef struct packed {
        logic signed [DS-1:0] d;
        logic                 last;
    } exp_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          RST, START, MODE;
    logic [DS-1:0] SIZE_I_IN, SIZE_J_IN, DATA_B_IN, DATA_A_IN;
    logic          DATA_B_IN_ENABLE, DATA_A_IN_ENABLE;
    logic          DATA_OUT_ENABLE, DATA_OUT_LAST, READY, ERROR;
    logic [DS-1:0] DATA_OUT;

    model_matrix_vector_product_stream #(.DATA_SIZE(DS), .MAX_SIZE(MS), .ADDR_SIZE(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE),
        .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN),
        .DATA_B_IN_ENABLE(DATA_B_IN_ENABLE), .DATA_B_IN(DATA_B_IN),
        .DATA_A_IN_ENABLE(DATA_A_IN_ENABLE), .DATA_A_IN(DATA_A_IN),
        .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .DATA_OUT_LAST(DATA_OUT_LAST),
        .DATA_OUT(DATA_OUT), .READY(READY), .ERROR(ERROR)
    );

    exp_t q_out[$];
    bit   q_rdy[$];
    int   errors = 0, checks = 0, ready_cnt = 0, timeouts = 0;
    bit   done_flag = 0, tb_a_last = 0;

    logic signed [DS-1:0] Am [MS][MS];
    logic signed [DS-1:0] bv [MS];
    logic signed [DS-1:0] hexp [MS];

    localparam logic signed [DS-1:0] MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [DS-1:0] MINV = 64'sh8000_0000_0000_0000;

    function automatic logic signed [DS-1:0] sat64(input logic signed [131:0] v);
        logic signed [131:0] mx, mn;
        mx = MAXV;
        mn = MINV;
        if (v > mx) return MAXV;
        if (v < mn) return MINV;
        return v[DS-1:0];
    endfunction

    // Monitor: reset values, scoreboard pops, first-output latency, final summary.
    int  lat_arm = 0;
    bit  fin = 0;
    always @(negedge CLK) begin
        if (!RST) begin
            checks++;
            if ({DATA_OUT_ENABLE, DATA_OUT_LAST, READY, ERROR} != 4'b0 || DATA_OUT != '0) begin
                errors++;
                $display("FAIL reset_outputs en=%b last=%b rdy=%b err=%b out=%0h want all 0",
                         DATA_OUT_ENABLE, DATA_OUT_LAST, READY, ERROR, DATA_OUT);
            end
            lat_arm = 0;
        end else begin
            if (lat_arm == 2) begin
                checks++;
                if (DATA_OUT_ENABLE !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_early en=%b want 0", DATA_OUT_ENABLE);
                end
                lat_arm = 1;
            end else if (lat_arm == 1) begin
                checks++;
                if (DATA_OUT_ENABLE !== 1'b1) begin
                    errors++;
                    $display("FAIL latency_first en=%b want 1", DATA_OUT_ENABLE);
                end
                lat_arm = 0;
            end
            if (DATA_A_IN_ENABLE && tb_a_last) lat_arm = 2;

            if (DATA_OUT_ENABLE) begin
                checks++;
                if (q_out.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got=%0d want none", $signed(DATA_OUT));
                end else begin
                    exp_t e;
                    e = q_out.pop_front();
                    if ($signed(DATA_OUT) !== e.d || DATA_OUT_LAST !== e.last) begin
                        errors++;
                        $display("FAIL out_data got=%0d last=%b want=%0d last=%b",
                                 $signed(DATA_OUT), DATA_OUT_LAST, e.d, e.last);
                    end
                end
            end
            if (READY) begin
                checks++;
                ready_cnt++;
                if (q_rdy.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready err=%b", ERROR);
                end else begin
                    bit we;
                    we = q_rdy.pop_front();
                    if (ERROR !== we || DATA_OUT_ENABLE !== 1'b0 || q_out.size() != 0) begin
                        errors++;
                        $display("FAIL ready_flags err=%b en=%b pending=%0d want err=%b en=0 pending=0",
                                 ERROR, DATA_OUT_ENABLE, q_out.size(), we);
                    end
                end
            end
        end

        if (done_flag && !fin) begin
            fin = 1;
            checks++;
            if (q_out.size() != 0) begin
                errors++;
                $display("FAIL out_left got=%0d want=0", q_out.size());
            end
            checks++;
            if (q_rdy.size() != 0) begin
                errors++;
                $display("FAIL ready_left got=%0d want=0", q_rdy.size());
            end
            checks++;
            if (timeouts != 0) begin
                errors++;
                $display("FAIL timeouts got=%0d want=0", timeouts);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic idle_inputs();
        START = 0; DATA_B_IN_ENABLE = 0; DATA_A_IN_ENABLE = 0; tb_a_last = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start(input bit mode, input int ni, input int nj);
        START = 1; MODE = mode; SIZE_I_IN = DS'(ni); SIZE_J_IN = DS'(nj);
        tick();
        START = 0; MODE = ~mode; SIZE_I_IN = '0; SIZE_J_IN = '0;
    endtask

    task automatic wait_ready(input int rc0);
        int t;
        for (t = 0; t < 400 && ready_cnt == rc0; t++) @(posedge CLK);
        if (ready_cnt == rc0) begin
            timeouts++;
            $display("FAIL ready_timeout waited=%0d cycles", t);
        end
        tick();
    endtask

    task automatic feed_b(input int nb, input bit gaps, input bit noise);
        for (int k = 0; k < nb; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                DATA_B_IN_ENABLE = 0; DATA_A_IN_ENABLE = 0;
                tick();
            end
            DATA_B_IN_ENABLE = 1; DATA_B_IN = bv[k];
            DATA_A_IN_ENABLE = noise; DATA_A_IN = {$urandom, $urandom};
            tick();
        end
        idle_inputs();
    endtask

    task automatic feed_a(input bit mode, input int ni, input int nj, input int cnt,
                          input bit gaps, input bit noise, input bit restart);
        for (int n = 0; n < cnt; n++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                DATA_A_IN_ENABLE = 0; DATA_B_IN_ENABLE = 0; tb_a_last = 0;
                tick();
            end
            DATA_A_IN_ENABLE = 1; DATA_A_IN = Am[n / nj][n % nj];
            tb_a_last = (n == ni*nj - 1);
            DATA_B_IN_ENABLE = noise; DATA_B_IN = {$urandom, $urandom};
            if (restart && n == 3) begin
                START = 1; MODE = ~mode; SIZE_I_IN = 1; SIZE_J_IN = 1;
            end
            tick();
            START = 0;
        end
        idle_inputs();
    endtask

    task automatic run(input bit mode, input int ni, input int nj, input bit gaps,
                       input bit noise, input bit restart, input int nexp);
        logic signed [131:0] acc, ae, be;
        int ny, nb, rc0;
        ny = mode ? nj : ni;
        nb = mode ? ni : nj;
        for (int y = 0; y < ny; y++) begin
            exp_t e;
            if (nexp > 0) e.d = hexp[y];
            else begin
                acc = '0;
                for (int x = 0; x < nb; x++) begin
                    ae = mode ? Am[x][y] : Am[y][x];
                    be = bv[x];
                    acc = acc + ae * be;
                end
                e.d = sat64(acc);
            end
            e.last = (y == ny - 1);
            q_out.push_back(e);
        end
        q_rdy.push_back(1'b0);
        rc0 = ready_cnt;
        pulse_start(mode, ni, nj);
        feed_b(nb, gaps, noise);
        feed_a(mode, ni, nj, ni*nj, gaps, noise, restart);
        wait_ready(rc0);
    endtask

    task automatic err_run(input int ni, input int nj);
        int rc0;
        q_rdy.push_back(1'b1);
        rc0 = ready_cnt;
        pulse_start(1'b0, ni, nj);
        wait_ready(rc0);
    endtask

    task automatic load_2x3();
        Am[0][0] = 1; Am[0][1] = 2; Am[0][2] = 3;
        Am[1][0] = 4; Am[1][1] = 5; Am[1][2] = 6;
    endtask

    initial begin
        RST = 0; MODE = 0; SIZE_I_IN = '0; SIZE_J_IN = '0; DATA_B_IN = '0; DATA_A_IN = '0;
        idle_inputs();
        repeat (3) tick();
        RST = 1;
        tick();

        load_2x3();
        bv[0] = 1; bv[1] = 0; bv[2] = -1;
        hexp[0] = -2; hexp[1] = -2;
        run(1'b0, 2, 3, 1'b0, 1'b0, 1'b0, 2);

        bv[0] = 1; bv[1] = 2;
        hexp[0] = 9; hexp[1] = 12; hexp[2] = 15;
        run(1'b1, 2, 3, 1'b0, 1'b1, 1'b0, 3);

        Am[0][0] = MAXV; Am[0][1] = MAXV; bv[0] = MAXV; bv[1] = MAXV;
        hexp[0] = MAXV;
        run(1'b0, 1, 2, 1'b0, 1'b0, 1'b0, 1);
        Am[0][0] = MINV; Am[0][1] = MINV;
        hexp[0] = MINV;
        run(1'b0, 1, 2, 1'b0, 1'b0, 1'b0, 1);

        err_run(0, 3);
        err_run(2, MS + 1);

        for (int i = 0; i < MS; i++) begin
            bv[i] = $signed($urandom);
            for (int j = 0; j < MS; j++) Am[i][j] = $signed($urandom);
        end
        run(1'b0, MS, MS, 1'b1, 1'b1, 1'b1, 0);
        run(1'b1, MS, MS, 1'b1, 1'b0, 1'b1, 0);

        // Abort a run in LOAD_A with garbage data, then check nothing stale survives.
        Am[0][0] = 64'sd1000; Am[0][1] = -64'sd777;
        bv[0] = 55; bv[1] = 66; bv[2] = 77;
        pulse_start(1'b0, 2, 3);
        feed_b(3, 1'b0, 1'b0);
        feed_a(1'b0, 2, 3, 2, 1'b0, 1'b0, 1'b0);
        RST = 0;
        repeat (3) tick();
        RST = 1;
        tick();

        load_2x3();
        bv[0] = 1; bv[1] = 0; bv[2] = -1;
        hexp[0] = -2; hexp[1] = -2;
        run(1'b0, 2, 3, 1'b1, 1'b0, 1'b0, 2);

        repeat (4) tick();
        done_flag = 1;
    end
endmodule
